// File: rtl/keccak_state_serializer_if.sv
// ----------------------------------------------------------------------------
// keccak_state_serializer_if : state-in / lane-beat-out handshake bundle
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface keccak_state_serializer_if #(
  parameter int LANE_W         = 64,
  parameter int LANES_PER_BEAT = 1
);
  localparam int c_state_w = 25 * LANE_W;
  localparam int c_beat_w  = LANES_PER_BEAT * LANE_W;

  logic [c_state_w-1:0] in_state;
  logic                 in_valid;
  logic                 in_ready;
  logic [c_beat_w-1:0]  out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_last;
  logic [4:0]           out_idx;
  logic                 abort;

  // Upstream producer / downstream consumer side.
  modport master (
    output in_state, in_valid, out_ready, abort,
    input  in_ready, out_data, out_valid, out_last, out_idx
  );

  // Serializer side.
  modport slave (
    input  in_state, in_valid, out_ready, abort,
    output in_ready, out_data, out_valid, out_last, out_idx
  );
endinterface

`default_nettype wire

// File: rtl/keccak_state_serializer.sv
// ----------------------------------------------------------------------------
// keccak_state_serializer : captures a 25-lane Keccak state, streams lane beats
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module keccak_state_serializer #(
  parameter int LANE_W         = 64,
  parameter int LANES_PER_BEAT = 1,
  parameter int ORDER          = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  keccak_state_serializer_if.slave bus
);

  localparam int         c_state_w = 25 * LANE_W;
  localparam int         c_beat_w  = LANES_PER_BEAT * LANE_W;
  localparam int         c_beats   = 25 / LANES_PER_BEAT;
  localparam logic [4:0] c_last    = 5'(c_beats - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t                r_state;
  logic [c_state_w-1:0]  r_shadow;
  logic [4:0]            r_beat_cnt;
  logic [c_beat_w-1:0]   r_out_data;
  logic                  r_out_valid;
  logic                  r_out_last;
  logic [4:0]            r_out_idx;
  logic [4:0]            w_cnt_inc;

  // Lane l (0-based) sits at bits [(24-l)*W +: W]; first lane of a beat goes to the MSBs.
  function automatic logic [c_beat_w-1:0] beat_slice(input logic [c_state_w-1:0] s,
                                                     input logic [4:0]           b);
    logic [c_beat_w-1:0] v;
    int                  l;
    v = '0;
    for (int j = 0; j < LANES_PER_BEAT; j++) begin
      if (ORDER == 0) l = int'(b) * LANES_PER_BEAT + j;
      else            l = 24 - int'(b) * LANES_PER_BEAT - j;
      v[(LANES_PER_BEAT-1-j)*LANE_W +: LANE_W] = s[(24-l)*LANE_W +: LANE_W];
    end
    return v;
  endfunction

  assign w_cnt_inc = r_beat_cnt + 5'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_shadow    <= '0;
      r_beat_cnt  <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_idx   <= '0;
    end else if (bus.abort) begin
      // Shadow is deliberately kept; only the stream position is dropped.
      r_state     <= ST_IDLE;
      r_beat_cnt  <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_idx   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_state     <= ST_SEND;
            r_shadow    <= bus.in_state;
            r_beat_cnt  <= '0;
            r_out_data  <= beat_slice(bus.in_state, 5'd0);
            r_out_valid <= 1'b1;
            r_out_last  <= (c_last == 5'd0);
            r_out_idx   <= '0;
          end
        end
        ST_SEND: begin
          if (bus.out_ready) begin
            if (r_out_last) begin
              if (bus.in_valid) begin
                r_shadow    <= bus.in_state;
                r_beat_cnt  <= '0;
                r_out_data  <= beat_slice(bus.in_state, 5'd0);
                r_out_valid <= 1'b1;
                r_out_last  <= (c_last == 5'd0);
                r_out_idx   <= '0;
              end else begin
                r_state     <= ST_IDLE;
                r_beat_cnt  <= '0;
                r_out_data  <= '0;
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
                r_out_idx   <= '0;
              end
            end else begin
              r_beat_cnt  <= w_cnt_inc;
              r_out_data  <= beat_slice(r_shadow, w_cnt_inc);
              r_out_last  <= (w_cnt_inc == c_last);
              r_out_idx   <= w_cnt_inc;
            end
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_beat_cnt  <= '0;
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
          r_out_idx   <= '0;
          r_out_data  <= '0;
        end
      endcase
    end
  end

  // Accepting a new state on the last accepted beat gives zero-bubble back-to-back streams.
  assign bus.in_ready  = (r_state == ST_IDLE) |
                         ((r_state == ST_SEND) & r_out_last & bus.out_ready);
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.out_last  = r_out_last;
  assign bus.out_idx   = r_out_idx;

endmodule

`default_nettype wire

// File: tb/tb_keccak_state_serializer.sv
// ----------------------------------------------------------------------------
// tb_keccak_state_serializer : three serializer configurations against a lane-stream model
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_keccak_state_serializer;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1599:0] tb_state = '0;
  logic          tb_in_valid = 1'b0;
  logic          tb_out_ready = 1'b0;
  logic          tb_abort = 1'b0;
  int            n_checks = 0;
  int            n_errors = 0;

  always #5 clk = ~clk;

  keccak_state_serializer_if #(.LANE_W(64), .LANES_PER_BEAT(1)) b0 ();
  keccak_state_serializer_if #(.LANE_W(64), .LANES_PER_BEAT(1)) b1 ();
  keccak_state_serializer_if #(.LANE_W(64), .LANES_PER_BEAT(5)) b2 ();

  assign b0.in_state = tb_state;  assign b0.in_valid = tb_in_valid;
  assign b0.out_ready = tb_out_ready;  assign b0.abort = tb_abort;
  assign b1.in_state = tb_state;  assign b1.in_valid = tb_in_valid;
  assign b1.out_ready = tb_out_ready;  assign b1.abort = tb_abort;
  assign b2.in_state = tb_state;  assign b2.in_valid = tb_in_valid;
  assign b2.out_ready = tb_out_ready;  assign b2.abort = tb_abort;

  keccak_state_serializer #(.LANE_W(64), .LANES_PER_BEAT(1), .ORDER(0)) u0 (
    .clk(clk), .reset(reset), .bus(b0.slave));
  keccak_state_serializer #(.LANE_W(64), .LANES_PER_BEAT(1), .ORDER(1)) u1 (
    .clk(clk), .reset(reset), .bus(b1.slave));
  keccak_state_serializer #(.LANE_W(64), .LANES_PER_BEAT(5), .ORDER(0)) u2 (
    .clk(clk), .reset(reset), .bus(b2.slave));

  logic         ov [3];
  logic         ol [3];
  logic         ir [3];
  logic [4:0]   oi [3];
  logic [319:0] od [3];

  assign ov[0] = b0.out_valid;  assign ol[0] = b0.out_last;  assign ir[0] = b0.in_ready;
  assign oi[0] = b0.out_idx;    assign od[0] = 320'(b0.out_data);
  assign ov[1] = b1.out_valid;  assign ol[1] = b1.out_last;  assign ir[1] = b1.in_ready;
  assign oi[1] = b1.out_idx;    assign od[1] = 320'(b1.out_data);
  assign ov[2] = b2.out_valid;  assign ol[2] = b2.out_last;  assign ir[2] = b2.in_ready;
  assign oi[2] = b2.out_idx;    assign od[2] = 320'(b2.out_data);

  // Reference: each DUT holds a captured list of 25 lanes and a beat position.
  int          lpb [3] = '{1, 1, 5};
  int          ord [3] = '{0, 1, 0};
  bit          m_send [3];
  int          m_cnt [3];
  logic [63:0] m_lanes [3][25];
  logic [63:0] cur [25];

  task automatic load(input int mode, input int base);
    for (int k = 0; k < 25; k++) begin
      if (mode == 0) cur[k] = 64'(base + k + 1);
      else           cur[k] = {$urandom(), $urandom()};
      tb_state[(24-k)*64 +: 64] = cur[k];
    end
  endtask

  function automatic logic [319:0] exp_beat(input int d);
    logic [63:0]  stream [25];
    logic [319:0] acc;
    acc = '0;
    for (int k = 0; k < 25; k++)
      stream[k] = (ord[d] == 1) ? m_lanes[d][24-k] : m_lanes[d][k];
    for (int j = 0; j < lpb[d]; j++)
      acc = (acc << 64) | 320'(stream[m_cnt[d]*lpb[d] + j]);
    return acc;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_send[d] = 1'b0;
      m_cnt[d]  = 0;
    end
  endtask

  task automatic model_capture(input int d);
    for (int k = 0; k < 25; k++) m_lanes[d][k] = cur[k];
    m_send[d] = 1'b1;
    m_cnt[d]  = 0;
  endtask

  task automatic model_update();
    for (int d = 0; d < 3; d++) begin
      if (reset || tb_abort) begin
        m_send[d] = 1'b0;
        m_cnt[d]  = 0;
      end else if (!m_send[d]) begin
        if (tb_in_valid) model_capture(d);
      end else if (tb_out_ready) begin
        if (m_cnt[d] == 25 / lpb[d] - 1) begin
          if (tb_in_valid) model_capture(d);
          else             m_send[d] = 1'b0;
        end else begin
          m_cnt[d] = m_cnt[d] + 1;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input int d, input logic [319:0] obs,
                     input logic [319:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s u%0d observed=%0h expected=%0h", tag, d, obs, exp);
    end
  endtask

  task automatic check_all();
    bit e_last;
    #1;
    for (int d = 0; d < 3; d++) begin
      e_last = m_send[d] && (m_cnt[d] == 25 / lpb[d] - 1);
      chk("out_valid", d, 320'(ov[d]), 320'(m_send[d]));
      chk("out_last",  d, 320'(ol[d]), 320'(e_last));
      chk("out_idx",   d, 320'(oi[d]), m_send[d] ? 320'(m_cnt[d]) : 320'(0));
      chk("out_data",  d, od[d],       m_send[d] ? exp_beat(d) : 320'(0));
      chk("in_ready",  d, 320'(ir[d]), 320'(!m_send[d] || (e_last && tb_out_ready)));
    end
  endtask

  task automatic step(input bit iv, input bit ordy, input bit ab);
    tb_in_valid  = iv;
    tb_out_ready = ordy;
    tb_abort     = ab;
    check_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    check_all();
    @(negedge clk);
    reset = 1'b0;

    // Ascending lanes, free-flowing sink.
    load(0, 0);
    step(1'b1, 1'b1, 1'b0);
    repeat (30) step(1'b0, 1'b1, 1'b0);

    // Sink stalls three cycles on beat 7.
    load(0, 0);
    step(1'b1, 1'b1, 1'b0);
    repeat (7) step(1'b0, 1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    repeat (26) step(1'b0, 1'b1, 1'b0);

    // State A then B with in_valid held: B follows A without a bubble.
    load(0, 0);
    step(1'b1, 1'b1, 1'b0);
    load(0, 100);
    repeat (25) step(1'b1, 1'b1, 1'b0);
    repeat (30) step(1'b0, 1'b1, 1'b0);

    // Asynchronous reset in the middle of beat 10, then a fresh state.
    load(1, 0);
    step(1'b1, 1'b1, 1'b0);
    repeat (10) step(1'b0, 1'b1, 1'b0);
    #2 reset = 1'b1;
    model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b0;
    load(1, 0);
    step(1'b1, 1'b1, 1'b0);
    repeat (30) step(1'b0, 1'b1, 1'b0);

    // Abort at beat 10, then a fresh state.
    load(1, 0);
    step(1'b1, 1'b1, 1'b0);
    repeat (10) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    repeat (2) step(1'b0, 1'b1, 1'b0);
    load(1, 0);
    step(1'b1, 1'b1, 1'b0);
    repeat (30) step(1'b0, 1'b1, 1'b0);

    // Random traffic: sporadic new states, sink stalls and rare aborts.
    repeat (400) begin
      if ($urandom_range(0, 3) == 0) load(1, 0);
      step($urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 40) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/keccak_state_serializer.md
Name: keccak_state_serializer

Overview:
- Captures a full Keccak-f state (25 lanes of LANE_W bits) in one handshake.
- Streams the state out as lane beats over a narrower valid/ready bus, LANES_PER_BEAT lanes per beat.
- Sits between the permutation core's state output and the absorb/squeeze datapath or an external bus.
- Generalises the fixed 1600-bit, 25×64-bit lane split to any lane width, beat width and lane order, with buffering and backpressure.

Parameters:
- LANE_W, 64, lane width in bits; legal values 8, 16, 32, 64 (state = 25*LANE_W bits).
- LANES_PER_BEAT, 1, lanes per output beat; legal values 1, 5, 25 (BEATS = 25/LANES_PER_BEAT).
- ORDER, 0, 0 = lane 1 emitted first; 1 = lane 25 emitted first.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_state  input  25*LANE_W  state word; lane k (1..25) = in_state[(26-k)*LANE_W-1 : (25-k)*LANE_W], so lane 1 is the MSBs.
- in_valid  input  1  in_state valid.
- in_ready  output  1  block can accept a state this cycle.
- out_data  output  LANES_PER_BEAT*LANE_W  current beat; first lane of the beat in the MSBs.
- out_valid  output  1  out_data valid.
- out_ready  input  1  sink accepts the beat.
- out_last  output  1  current beat is the final beat of the state.
- out_idx  output  5  beat index 0..BEATS-1 of the current beat.
- abort  input  1  synchronous flush.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset).
- FSM: IDLE, SEND. Shadow register holds the state (25*LANE_W bits). Beat counter beat_cnt is 5 bits.
- Reset (async, any state, including mid-stream):
  - state = IDLE, shadow = 0, beat_cnt = 0.
  - Outputs: out_valid = 0, out_last = 0, out_idx = 0, out_data = 0, in_ready = 1.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - in_valid = 1 → capture in_state into shadow, beat_cnt = 0, go to SEND.
  - First beat is valid the next cycle (latency 1).
- SEND:
  - out_valid = 1.
  - out_data = lanes of beat beat_cnt, taken from shadow.
  - ORDER = 0: beat b carries lanes b*LPB+1 .. b*LPB+LPB.
  - ORDER = 1: beat b carries lanes 25-b*LPB down to 25-b*LPB-LPB+1. Lane order within the beat is reversed too, so stream order is strictly 25, 24, ..., 1.
  - out_idx = beat_cnt; out_last = (beat_cnt == BEATS-1).
  - out_valid & out_ready & !out_last → beat_cnt + 1.
  - out_valid & out_ready & out_last:
    - If in_valid = 1: capture the new state, beat_cnt = 0, stay in SEND (zero-bubble back-to-back).
    - Otherwise: go to IDLE.
- in_ready = (state == IDLE) | (state == SEND & out_last & out_ready). This is combinational from out_ready and is the only combinational input-to-output path.
- Backpressure: while out_valid = 1 and out_ready = 0, out_data, out_idx and out_last hold stable. out_valid never drops before the beat is accepted.
- in_valid in SEND when not on an accepted last beat: ignored (in_ready = 0). The upstream must hold the state.
- abort = 1:
  - Next edge: state = IDLE, beat_cnt = 0; shadow is retained; no beat is accepted that cycle.
  - abort has priority over capture and advance.
- LANES_PER_BEAT = 25: BEATS = 1. out_last is always 1 in SEND; out_data is the full state (lane-reversed when ORDER = 1).
- No arithmetic beyond the beat counter. The counter never exceeds BEATS-1 (it is cleared on the last beat), so no wrap-around.

Test Plan:
- LANE_W=64, LPB=1, ORDER=0; lane k = 64'h k (lane 1 = 1 … lane 25 = 25); out_ready = 1 → out_data sequence 1..25, out_idx 0..24, out_last only on the beat with 25. First beat 1 cycle after capture; 25 consecutive cycles; then IDLE with in_ready = 1.
- Same stimulus with ORDER=1 → sequence 25..1, out_last on lane 1.
- LANE_W=64, LPB=5, ORDER=0 → beat 0 = {1,2,3,4,5} (lane 1 at MSBs), beat 4 = {21..25} with out_last; 5 beats total.
- LPB=1; drop out_ready for 3 cycles at beat 7 → out_data = 8 and out_idx = 7 held stable all 3 cycles; stream resumes with 9, and no beat is lost or duplicated.
- Two states A (lane k = k) and B (lane k = 100+k); in_valid held high → in_ready = 1 on A's last beat; B's lane 1 (= 101) appears the cycle after A's lane 25, with no bubble.
- Assert reset (async, mid-cycle) at beat 10, and separately pulse abort at beat 10 → outputs go to reset values; in_ready = 1. A fresh state C then streams from beat 0 correctly.
